// File: rtl/sram_monitor_pkg.sv
// Shared definitions for the SRAM write monitor.
//   mon_state_e  : monitor FSM states (idle / armed / frozen)
//   DEFAULT_POLY : default MISR feedback polynomial for 16-bit data
//   region_t     : one allowed-write region, inclusive {base, limit}.
//                  Fields are REGION_ADDR_MAX_W wide so the record is usable
//                  for any address width up to that size; narrower
//                  addresses are zero-extended before comparison.
package sram_monitor_pkg;

    typedef enum logic [1:0] {
        S_MON_IDLE   = 2'd0,
        S_MON_ARMED  = 2'd1,
        S_MON_FROZEN = 2'd2
    } mon_state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    localparam int REGION_ADDR_MAX_W = 32;

    typedef struct packed {
        logic [REGION_ADDR_MAX_W-1:0] base;
        logic [REGION_ADDR_MAX_W-1:0] limit;
    } region_t;

endpackage

// File: rtl/sram_monitor_region.sv
// One monitored address region: range match, saturating write counter,
// write-order checker and MISR data signature.
// Ports:
//   clock_50, reset     : clock, asynchronous active-high reset
//   clear               : synchronous clear of all statistics (arm)
//   region              : inclusive {base, limit}; base > limit never matches
//   address, data       : registered write (pipeline stage 1)
//   update              : this region owns the stage-1 write (after priority)
//   hit                 : combinational range match of 'address'
//   write_count         : accepted writes (saturating)
//   order_error_count   : writes not at previous address + 1 (saturating)
//   signature           : MISR over written data
module sram_monitor_region
    import sram_monitor_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int CNT_W = 20,
    parameter logic [DATA_W-1:0] POLY = DATA_W'(DEFAULT_POLY),
    parameter bit CHECK_ORDER = 1'b1
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              clear,
    input  region_t           region,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              update,
    output logic              hit,
    output logic [CNT_W-1:0]  write_count,
    output logic [CNT_W-1:0]  order_error_count,
    output logic [DATA_W-1:0] signature
);

    logic [REGION_ADDR_MAX_W-1:0] address_ext;
    logic [DATA_W-1:0]            misr_next;
    logic [ADDR_W-1:0]            expected_address;
    logic                         seen;

    assign address_ext = REGION_ADDR_MAX_W'(address);
    assign hit = (region.base <= address_ext) && (address_ext <= region.limit);

    always_comb begin
        misr_next = {signature[DATA_W-2:0], 1'b0} ^ data;
        if (signature[DATA_W-1]) begin
            misr_next = misr_next ^ POLY;
        end
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            write_count       <= '0;
            order_error_count <= '0;
            signature         <= '0;
            expected_address  <= '0;
            seen              <= 1'b0;
        end else if (clear) begin
            write_count       <= '0;
            order_error_count <= '0;
            signature         <= '0;
            expected_address  <= '0;
            seen              <= 1'b0;
        end else if (update) begin
            if (write_count != '1) begin
                write_count <= write_count + CNT_W'(1);
            end
            signature <= misr_next;
            // The first write after arming only establishes the sequence.
            if (CHECK_ORDER && seen && (address != expected_address) &&
                (order_error_count != '1)) begin
                order_error_count <= order_error_count + CNT_W'(1);
            end
            expected_address <= address + ADDR_W'(1);
            seen             <= 1'b1;
        end
    end

endmodule

// File: rtl/sram_write_monitor.sv
// SRAM write-port monitor. Watches address / data / active-low write enable
// and checks every write against NUM_REGIONS allowed regions.
// Ports:
//   clock_50, reset          : clock, asynchronous active-high reset
//   arm                      : pulse, clear statistics and start monitoring
//   stop                     : pulse, freeze statistics (arm wins if both)
//   region_base/limit        : inclusive bounds per region (ADDR_W <= 32)
//   sram_address, sram_write_data, sram_we_n : observed SRAM write port
//   monitor_active           : high while armed
//   mon_state                : current FSM state (debug)
//   write_count, order_error_count, signature : per-region statistics
//   violation_count          : writes matching no region (saturating)
//   first_violation_*        : sticky capture of the first such write
// Timing: a write is registered in stage 1, statistics update in stage 2,
// so outputs reflect a write two cycles after the write cycle.
module sram_write_monitor
    import sram_monitor_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int NUM_REGIONS = 2,
    parameter int CNT_W = 20,
    parameter logic [DATA_W-1:0] POLY = DATA_W'(DEFAULT_POLY),
    parameter bit CHECK_ORDER = 1'b1
) (
    input  logic                               clock_50,
    input  logic                               reset,
    input  logic                               arm,
    input  logic                               stop,
    input  logic [NUM_REGIONS-1:0][ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS-1:0][ADDR_W-1:0] region_limit,
    input  logic [ADDR_W-1:0]                  sram_address,
    input  logic [DATA_W-1:0]                  sram_write_data,
    input  logic                               sram_we_n,
    output logic                               monitor_active,
    output mon_state_e                         mon_state,
    output logic [NUM_REGIONS-1:0][CNT_W-1:0]  write_count,
    output logic [NUM_REGIONS-1:0][CNT_W-1:0]  order_error_count,
    output logic [NUM_REGIONS-1:0][DATA_W-1:0] signature,
    output logic [CNT_W-1:0]                   violation_count,
    output logic                               first_violation_valid,
    output logic [ADDR_W-1:0]                  first_violation_address,
    output logic [DATA_W-1:0]                  first_violation_data
);

    mon_state_e             state;
    logic                   s1_valid;
    logic [ADDR_W-1:0]      s1_address;
    logic [DATA_W-1:0]      s1_data;
    logic [NUM_REGIONS-1:0] hits;
    logic [NUM_REGIONS-1:0] grant;
    logic                   any_hit;

    assign mon_state      = state;
    assign monitor_active = (state == S_MON_ARMED);

    // Arm takes priority over stop in every state.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state <= S_MON_IDLE;
        end else if (arm) begin
            state <= S_MON_ARMED;
        end else if ((state == S_MON_ARMED) && stop) begin
            state <= S_MON_FROZEN;
        end
    end

    // Stage 1: capture writes seen while armed; a write coinciding with arm
    // is dropped, and arm also discards whatever is already in flight.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_address <= '0;
            s1_data    <= '0;
        end else begin
            s1_valid <= !arm && (state == S_MON_ARMED) && !sram_we_n;
            if (!sram_we_n) begin
                s1_address <= sram_address;
                s1_data    <= sram_write_data;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGIONS; g++) begin : g_region
            region_t region;
            assign region.base  = REGION_ADDR_MAX_W'(region_base[g]);
            assign region.limit = REGION_ADDR_MAX_W'(region_limit[g]);

            sram_monitor_region #(
                .ADDR_W     (ADDR_W),
                .DATA_W     (DATA_W),
                .CNT_W      (CNT_W),
                .POLY       (POLY),
                .CHECK_ORDER(CHECK_ORDER)
            ) u_region (
                .clock_50         (clock_50),
                .reset            (reset),
                .clear            (arm),
                .region           (region),
                .address          (s1_address),
                .data             (s1_data),
                .update           (s1_valid && grant[g]),
                .hit              (hits[g]),
                .write_count      (write_count[g]),
                .order_error_count(order_error_count[g]),
                .signature        (signature[g])
            );
        end
    endgenerate

    // Lowest-index matching region owns an address covered by overlaps.
    always_comb begin
        grant = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    assign any_hit = |hits;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            violation_count         <= '0;
            first_violation_valid   <= 1'b0;
            first_violation_address <= '0;
            first_violation_data    <= '0;
        end else if (arm) begin
            violation_count         <= '0;
            first_violation_valid   <= 1'b0;
            first_violation_address <= '0;
            first_violation_data    <= '0;
        end else if (s1_valid && !any_hit) begin
            if (violation_count != '1) begin
                violation_count <= violation_count + CNT_W'(1);
            end
            if (!first_violation_valid) begin
                first_violation_valid   <= 1'b1;
                first_violation_address <= s1_address;
                first_violation_data    <= s1_data;
            end
        end
    end

endmodule

// File: doc/sram_write_monitor.md
Name: sram_write_monitor

Overview:
Synthesizable, parametrised monitor that watches the project's SRAM write port (address, write data, active-low write enable) and checks every write against a configurable set of address regions. Per region it keeps write counts, a write-order check and a MISR data signature. Writes that fall outside every region are counted and the first one is captured. It is instantiated beside the milestone datapaths in project, so the checking is also available on the board, not only in simulation.

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
NUM_REGIONS, 2, number of allowed-write regions
CNT_W, 20, width of all counters (saturating)
POLY, 16'h1021, MISR feedback polynomial (DATA_W bits)
CHECK_ORDER, 1, 1 = flag non-sequential writes within a region

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Arm  in  1  pulse: clear all statistics, start monitoring
Stop  in  1  pulse: freeze statistics
Region_base  in  NUM_REGIONS x ADDR_W  inclusive lower bound per region
Region_limit  in  NUM_REGIONS x ADDR_W  inclusive upper bound per region
SRAM_address  in  ADDR_W  address driven to SRAM
SRAM_write_data  in  DATA_W  data driven to SRAM
SRAM_we_n  in  1  active-low write enable
Monitor_active  out  1  high in ARMED state
Write_count  out  NUM_REGIONS x CNT_W  accepted writes per region
Order_error_count  out  NUM_REGIONS x CNT_W  non-sequential writes per region
Signature  out  NUM_REGIONS x DATA_W  MISR of data written per region
Violation_count  out  CNT_W  writes outside all regions
First_violation_valid  out  1  sticky; set on first violation
First_violation_address  out  ADDR_W  address of first violation
First_violation_data  out  DATA_W  data of first violation

Behaviour:
- Reset: state S_MON_IDLE. All outputs 0. Per-region expected-address registers 0. Per-region seen flags 0.
- States:
  - S_MON_IDLE: Arm -> S_MON_ARMED.
  - S_MON_ARMED: Stop -> S_MON_FROZEN. Arm -> re-clear, stay in S_MON_ARMED.
  - S_MON_FROZEN: Arm -> S_MON_ARMED. Outputs hold.
- Arm clears every counter, signature, seen flag and First_violation_* in the same cycle.
- Arm and Stop in the same cycle: Arm wins, Stop is ignored.
- A write cycle with Arm asserted is discarded.
- Stage 1: SRAM_we_n==0 in S_MON_ARMED registers address, data and a valid bit.
- Stage 2: region match and statistics update. Outputs reflect a write 2 cycles after the write cycle.
- A write still in flight when Stop arrives is still counted.
- Region match: base <= addr <= limit. If regions overlap, the lowest index wins. A region with base > limit never matches.
- Matched region i, all in stage 2:
  - Write_count[i] increments.
  - Signature[i] = (sig<<1) ^ (sig[DATA_W-1] ? POLY : 0) ^ data.
  - If CHECK_ORDER, seen[i]=1 and addr != expected[i]: Order_error_count[i] increments.
  - Then expected[i] = addr+1, wrapping modulo 2^ADDR_W, and seen[i] = 1.
- No region matched: Violation_count increments. If First_violation_valid==0, capture address and data and set valid. Later violations do not overwrite the capture.
- All counters saturate at all-ones and never wrap.
- SRAM_we_n high: no update.
- Reset mid-operation clears everything immediately, including the pipeline valid bit. In-flight writes are lost.

Decomposition:
- Package sram_monitor_pkg holds:
  - state enum (S_MON_IDLE, S_MON_ARMED, S_MON_FROZEN);
  - the default POLY constant;
  - region record typedef {base, limit}.
- Sub-module sram_monitor_region: one region's match, count, order and MISR logic, generated NUM_REGIONS times. The priority encoder and violation capture stay in the top module.

Test Plan:
1. Reset, Arm; regions {0..146943, 146944..262143}; one write 0x1234 to 146944 -> after 2 cycles Write_count[1]=1, Signature[1]=0x1234, Violation_count=0.
2. Writes 0x1234 then 0x0001 to 146944, 146945 -> Signature[1]=0x2469, Order_error_count[1]=0.
3. Writes to 146944, 146946, 146947 -> Order_error_count[1]=1, Write_count[1]=3.
4. Region 0 base=1, limit=0; write 0x00AB to address 5 -> Violation_count=1, First_violation_address=5, First_violation_data=0x00AB. A second violation at address 7 -> count 2, capture unchanged.
5. Arm and Stop in the same cycle as a write -> state ARMED, write not counted. Next Stop, then 3 writes -> all counts unchanged.
6. CNT_W=2, 5 writes to region 0 -> Write_count[0]=3 (saturated). Reset asserted mid-stream -> all outputs 0 on the next edge.
